// File: rtl/instr_encode_loader.sv
// Program loader: packs decoded MIPS fields into R/I/J words and streams them
// into instruction memory at consecutive word addresses through a one-deep pending stage.
module instr_encode_loader #(
  parameter int          MEM_DEPTH = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         finish,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [1:0]                   fmt,
  input  logic [5:0]                   opcode,
  input  logic [4:0]                   rs,
  input  logic [4:0]                   rt,
  input  logic [4:0]                   rd,
  input  logic [4:0]                   shamt,
  input  logic [5:0]                   funct,
  input  logic [15:0]                  immediate,
  input  logic [25:0]                  address,
  output logic                         mem_we,
  output logic [31:0]                  mem_addr,
  output logic [31:0]                  mem_wdata,
  output logic [$clog2(MEM_DEPTH):0]   word_count,
  output logic                         busy,
  output logic                         done,
  output logic                         full,
  output logic                         err_fmt
);
  localparam int CW = $clog2(MEM_DEPTH) + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, DONE = 2'd2} state_t;
  typedef struct packed {
    logic        vld;
    logic [31:0] word;
  } pend_t;

  state_t      state, state_nxt;
  pend_t       pend;
  logic [31:0] enc;
  logic        legal, accept, last_wr, enter_load;
  logic [CW:0] occ;

  // Legal words must decode back to their own format: opcode 0 is R, 2/3 are J.
  always_comb begin
    enc   = '0;
    legal = 1'b0;
    case (fmt)
      2'd0: begin
        enc   = {6'h00, rs, rt, rd, shamt, funct};
        legal = 1'b1;
      end
      2'd1: begin
        enc   = {opcode, rs, rt, immediate};
        legal = !(opcode == 6'd0 || opcode == 6'd2 || opcode == 6'd3);
      end
      2'd2: begin
        enc   = {opcode, address};
        legal = (opcode == 6'd2 || opcode == 6'd3);
      end
      default: ;
    endcase
  end

  assign occ        = {1'b0, word_count} + (CW+1)'(pend.vld);
  assign accept     = in_valid && in_ready;
  assign last_wr    = pend.vld && (word_count == CW'(MEM_DEPTH - 1));
  assign enter_load = (state != LOAD) && (state_nxt == LOAD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // finish blocks new accepts, so any pending word is written in the finish cycle itself.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    if (last_wr || finish) state_nxt = DONE;
      DONE:    if (start) state_nxt = LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state == LOAD);
    done     = (state == DONE);
    in_ready = (state == LOAD) && (occ < (CW+1)'(MEM_DEPTH)) && !finish;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend       <= '0;
      word_count <= '0;
      full       <= 1'b0;
      err_fmt    <= 1'b0;
    end else begin
      pend.vld <= accept && legal;
      if (accept && legal) pend.word <= enc;
      err_fmt <= accept && !legal;
      if (enter_load) begin
        word_count <= '0;
        full       <= 1'b0;
      end else if (pend.vld) begin
        word_count <= word_count + CW'(1);
        if (last_wr) full <= 1'b1;
      end
    end
  end

  assign mem_we    = pend.vld;
  assign mem_wdata = pend.word;
  assign mem_addr  = BASE_ADDR + (32'(word_count) << 2);

endmodule

// File: tb/tb_instr_encode_loader.sv
// Directed bench for instr_encode_loader with MEM_DEPTH=4 so the full boundary is reachable.
module tb_instr_encode_loader;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, finish = 1'b0, in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  fmt = '0;
  logic [5:0]  opcode = '0, funct = '0;
  logic [4:0]  rs = '0, rt = '0, rd = '0, shamt = '0;
  logic [15:0] immediate = '0;
  logic [25:0] address = '0;
  logic        mem_we, busy, done, full, err_fmt;
  logic [31:0] mem_addr, mem_wdata;
  logic [2:0]  word_count;
  int          total = 0, passed = 0;

  instr_encode_loader #(.MEM_DEPTH(4), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .finish(finish),
    .in_valid(in_valid), .in_ready(in_ready), .fmt(fmt), .opcode(opcode),
    .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
    .immediate(immediate), .address(address), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .word_count(word_count),
    .busy(busy), .done(done), .full(full), .err_fmt(err_fmt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic new_session();
    finish = 1'b1; tick(); finish = 1'b0;
    pulse_start();
  endtask

  task automatic drive(input logic [1:0] f, input logic [5:0] op, input logic [4:0] s,
                       input logic [4:0] t, input logic [4:0] d, input logic [4:0] sh,
                       input logic [5:0] fn, input logic [15:0] imm, input logic [25:0] ad);
    in_valid = 1'b1; fmt = f; opcode = op; rs = s; rt = t; rd = d; shamt = sh;
    funct = fn; immediate = imm; address = ad;
  endtask

  task automatic test_reset();
    #2;
    total++; if (mem_we !== 1'b0) $display("FAIL rst_we got %0h want 0", mem_we); else passed++;
    total++; if (in_ready !== 1'b0) $display("FAIL rst_ready got %0h want 0", in_ready); else passed++;
    total++; if ({busy, done, full, err_fmt} !== 4'b0) $display("FAIL rst_flags got %b want 0000", {busy, done, full, err_fmt}); else passed++;
    total++; if (mem_addr !== 32'h0) $display("FAIL rst_addr got %0h want 0", mem_addr); else passed++;
    total++; if (mem_wdata !== 32'h0) $display("FAIL rst_wdata got %0h want 0", mem_wdata); else passed++;
    total++; if (word_count !== 3'd0) $display("FAIL rst_wc got %0d want 0", word_count); else passed++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_r_type();
    pulse_start();
    total++; if (busy !== 1'b1) $display("FAIL r_busy got %0h want 1", busy); else passed++;
    drive(2'd0, 6'h3f, 5'd9, 5'd10, 5'd8, 5'd0, 6'h20, 16'h0, 26'h0);
    total++; if (in_ready !== 1'b1) $display("FAIL r_ready got %0h want 1", in_ready); else passed++;
    tick(); in_valid = 1'b0;
    total++; if (mem_we !== 1'b1) $display("FAIL r_we got %0h want 1", mem_we); else passed++;
    total++; if (mem_addr !== 32'h0) $display("FAIL r_addr got %0h want 0", mem_addr); else passed++;
    total++; if (mem_wdata !== 32'h012A4020) $display("FAIL r_wdata got %h want 012a4020", mem_wdata); else passed++;
    tick();
    total++; if (word_count !== 3'd1) $display("FAIL r_wc got %0d want 1", word_count); else passed++;
    total++; if (mem_we !== 1'b0) $display("FAIL r_we_off got %0h want 0", mem_we); else passed++;
  endtask

  task automatic test_back_to_back();
    new_session();
    drive(2'd1, 6'd8, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'hFFFF, 26'h0);
    tick();
    drive(2'd2, 6'd2, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h0100000);
    total++; if (mem_we !== 1'b1 || mem_addr !== 32'h0 || mem_wdata !== 32'h2008FFFF)
      $display("FAIL b2b_w0 got we=%0h a=%h d=%h want we=1 a=0 d=2008ffff", mem_we, mem_addr, mem_wdata); else passed++;
    tick(); in_valid = 1'b0;
    total++; if (mem_we !== 1'b1 || mem_addr !== 32'h4 || mem_wdata !== 32'h08100000)
      $display("FAIL b2b_w1 got we=%0h a=%h d=%h want we=1 a=4 d=08100000", mem_we, mem_addr, mem_wdata); else passed++;
    tick();
    total++; if (mem_we !== 1'b0 || word_count !== 3'd2)
      $display("FAIL b2b_end got we=%0h wc=%0d want we=0 wc=2", mem_we, word_count); else passed++;
  endtask

  task automatic test_illegal();
    new_session();
    drive(2'd1, 6'd2, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h1234, 26'h0);
    tick(); in_valid = 1'b0;
    total++; if (err_fmt !== 1'b1) $display("FAIL ill_i_err got %0h want 1", err_fmt); else passed++;
    total++; if (mem_we !== 1'b0 || word_count !== 3'd0)
      $display("FAIL ill_i_nowr got we=%0h wc=%0d want we=0 wc=0", mem_we, word_count); else passed++;
    tick();
    total++; if (err_fmt !== 1'b0) $display("FAIL ill_pulse got %0h want 0", err_fmt); else passed++;
    drive(2'd3, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h0);
    tick();
    total++; if (err_fmt !== 1'b1 || mem_we !== 1'b0)
      $display("FAIL ill_f3 got err=%0h we=%0h want err=1 we=0", err_fmt, mem_we); else passed++;
    drive(2'd2, 6'd4, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h123);
    tick();
    total++; if (err_fmt !== 1'b1 || mem_we !== 1'b0)
      $display("FAIL ill_j4 got err=%0h we=%0h want err=1 we=0", err_fmt, mem_we); else passed++;
    drive(2'd0, 6'd0, 5'd0, 5'd0, 5'd1, 5'd0, 6'h20, 16'h0, 26'h0);
    tick(); in_valid = 1'b0;
    total++; if (err_fmt !== 1'b0 || mem_we !== 1'b1 || mem_addr !== 32'h0 || mem_wdata !== 32'h00000820)
      $display("FAIL ill_next got err=%0h we=%0h a=%h d=%h want err=0 we=1 a=0 d=00000820", err_fmt, mem_we, mem_addr, mem_wdata); else passed++;
    tick();
    total++; if (word_count !== 3'd1) $display("FAIL ill_wc got %0d want 1", word_count); else passed++;
  endtask

  task automatic test_full();
    new_session();
    for (int i = 0; i < 4; i++) begin
      drive(2'd2, 6'd3, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'(i + 16));
      total++; if (in_ready !== 1'b1) $display("FAIL full_ready%0d got %0h want 1", i, in_ready); else passed++;
      tick();
      total++; if (mem_we !== 1'b1 || mem_addr !== 32'(4 * i) || mem_wdata !== (32'h0C000000 | 32'(i + 16)))
        $display("FAIL full_w%0d got we=%0h a=%h d=%h want we=1 a=%h d=%h", i, mem_we, mem_addr, mem_wdata,
                 32'(4 * i), 32'h0C000000 | 32'(i + 16)); else passed++;
    end
    drive(2'd2, 6'd3, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'd99);
    total++; if (in_ready !== 1'b0) $display("FAIL full_block got %0h want 0", in_ready); else passed++;
    tick();
    total++; if (mem_we !== 1'b0 || full !== 1'b1 || done !== 1'b1 || word_count !== 3'd4)
      $display("FAIL full_state got we=%0h full=%0h done=%0h wc=%0d want 0 1 1 4", mem_we, full, done, word_count); else passed++;
    tick(); in_valid = 1'b0;
    total++; if (mem_we !== 1'b0 || in_ready !== 1'b0)
      $display("FAIL full_hold got we=%0h ready=%0h want 0 0", mem_we, in_ready); else passed++;
  endtask

  task automatic test_finish();
    pulse_start();
    total++; if (word_count !== 3'd0 || full !== 1'b0 || busy !== 1'b1)
      $display("FAIL fin_restart got wc=%0d full=%0h busy=%0h want 0 0 1", word_count, full, busy); else passed++;
    drive(2'd1, 6'd9, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h0005, 26'h0);
    tick();
    drive(2'd1, 6'd9, 5'd1, 5'd3, 5'd0, 5'd0, 6'd0, 16'h0006, 26'h0);
    tick(); in_valid = 1'b0; finish = 1'b1;
    total++; if (mem_we !== 1'b1 || mem_addr !== 32'h4 || mem_wdata !== 32'h24230006)
      $display("FAIL fin_w1 got we=%0h a=%h d=%h want 1 4 24230006", mem_we, mem_addr, mem_wdata); else passed++;
    tick(); finish = 1'b0;
    total++; if (done !== 1'b1 || busy !== 1'b0 || word_count !== 3'd2 || mem_we !== 1'b0)
      $display("FAIL fin_done got done=%0h busy=%0h wc=%0d we=%0h want 1 0 2 0", done, busy, word_count, mem_we); else passed++;
    pulse_start();
    total++; if (word_count !== 3'd0) $display("FAIL fin_wc0 got %0d want 0", word_count); else passed++;
    drive(2'd0, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'h08, 16'h0, 26'h0);
    tick(); in_valid = 1'b0;
    total++; if (mem_we !== 1'b1 || mem_addr !== 32'h0 || mem_wdata !== 32'h00000008)
      $display("FAIL fin_base got we=%0h a=%h d=%h want 1 0 00000008", mem_we, mem_addr, mem_wdata); else passed++;
    tick();
  endtask

  task automatic test_reset_pending();
    drive(2'd0, 6'd0, 5'd4, 5'd5, 5'd6, 5'd0, 6'h21, 16'h0, 26'h0);
    tick(); in_valid = 1'b0;
    total++; if (mem_we !== 1'b1) $display("FAIL rp_pend got %0h want 1", mem_we); else passed++;
    #2 rst_n = 1'b0; #1;
    total++; if (mem_we !== 1'b0 || busy !== 1'b0 || word_count !== 3'd0 || mem_wdata !== 32'h0 || mem_addr !== 32'h0)
      $display("FAIL rp_async got we=%0h busy=%0h wc=%0d d=%h a=%h want all 0", mem_we, busy, word_count, mem_wdata, mem_addr); else passed++;
    tick(); #2 rst_n = 1'b1;
    tick();
    total++; if (mem_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL rp_idle got we=%0h busy=%0h done=%0h want 0 0 0", mem_we, busy, done); else passed++;
    drive(2'd3, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h0);
    total++; if (in_ready !== 1'b0) $display("FAIL rp_ready got %0h want 0", in_ready); else passed++;
    tick(); in_valid = 1'b0;
    total++; if (err_fmt !== 1'b0 || mem_we !== 1'b0)
      $display("FAIL rp_noerr got err=%0h we=%0h want 0 0", err_fmt, mem_we); else passed++;
  endtask

  initial begin
    test_reset();
    test_r_type();
    test_back_to_back();
    test_illegal();
    test_full();
    test_finish();
    test_reset_pending();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
